// File: rtl/hd44780_led_pwm_pkg.sv
// Shared constants for the LED dimmer/blinker: register field layout and channel modes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hd44780_pkg;

  localparam int DATA_W   = 8;
  localparam int MODE_MSB = 7;
  localparam int MODE_LSB = 6;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF     = 2'b00;
  localparam mode_t MODE_STEADY  = 2'b01;
  localparam mode_t MODE_BLINK   = 2'b10;
  localparam mode_t MODE_BREATHE = 2'b11;

endpackage

// File: rtl/hd44780_led_pwm_if.sv
// Wishbone-style register access bundle for the LED dimmer (single-beat, no bursts).
// Latency: slave answers one clock after STB_I with ACK_O.
// Backpressure: master holds STB_I/WE_I/ADR_I/DAT_I until it has seen ACK_O.
//   STB_I  strobe, WE_I write enable, ADR_I channel select,
//   DAT_I  write data, DAT_O read data (valid with ACK_O), ACK_O one-cycle acknowledge.
interface hd44780_led_pwm_if;
  import hd44780_pkg::*;

  logic              STB_I;
  logic              WE_I;
  logic [1:0]        ADR_I;
  logic [DATA_W-1:0] DAT_I;
  logic [DATA_W-1:0] DAT_O;
  logic              ACK_O;

  modport master (output STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
  modport slave  (input STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);

endinterface

// File: rtl/hd44780_led_pwm_tick_div.sv
// Clock divider producing a single-cycle tick every DIV clocks (counter runs 0..DIV-1).
// Latency: tick_o is high during the cycle the counter holds DIV-1.
// Backpressure: none, free-running.
//   CLK_I clock, RST_I async active-high reset, tick_o one-cycle pulse.
module hd44780_tick_div #(
  parameter int DIV = 4
) (
  input  logic CLK_I,
  input  logic RST_I,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(DIV - 1));
  assign tick_o = last;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (last) cnt_d = '0;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hd44780_led_pwm.sv
// N-channel LED PWM dimmer with off/steady/blink/breathe modes behind an 8-bit-per-channel register bus.
// Latency: bus ACK one clock after STB; new settings take effect at the next PWM wrap; pwm_o lags pwm_ctr by one clock.
// Backpressure: held STB acks every other cycle; no stalls otherwise, PWM is free-running.
//   CLK_I clock, RST_I async active-high reset, bus register access (slave side),
//   pwm_o registered active-high PWM outputs, one per channel.
module hd44780_led_pwm
  import hd44780_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int PWM_BITS    = 3,
  parameter int TICK_DIV    = 24_000_000,
  parameter int BREATHE_DIV = 750_000
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  hd44780_led_pwm_if.slave  bus,
  output logic [NUM_CH-1:0] pwm_o
);

  typedef struct packed {
    mode_t               mode;
    logic [PWM_BITS-1:0] duty;
  } ch_reg_t;

  logic [PWM_BITS-1:0] ctr_q, ctr_d;
  logic                ctr_wrap;
  logic                blink_q, blink_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                ramp_dn_q, ramp_dn_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                blink_tick, breathe_tick;
  logic                wr_en;
  logic [DATA_W-1:0]   rd_dat;
  logic [DATA_W-1:0]   rd_vec [NUM_CH];

  hd44780_tick_div #(.DIV(TICK_DIV)) u_blink_div (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .tick_o (blink_tick)
  );

  hd44780_tick_div #(.DIV(BREATHE_DIV)) u_breathe_div (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .tick_o (breathe_tick)
  );

  // Bus side: the access completes in the ACK cycle, so writes land then.
  assign wr_en     = ack_q & bus.STB_I & bus.WE_I;
  assign bus.ACK_O = ack_q;
  assign bus.DAT_O = dat_q;

  // Out-of-range addresses match no channel and read back as zero.
  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ADR_I == 2'(i)) rd_dat = rd_vec[i];
    end
  end

  assign ctr_wrap = &ctr_q;

  always_comb begin
    ack_d     = bus.STB_I & ~ack_q;
    dat_d     = ack_d ? rd_dat : '0;
    ctr_d     = ctr_q + 1'b1;
    blink_d   = blink_q ^ blink_tick;
    ramp_d    = ramp_q;
    ramp_dn_d = ramp_dn_q;
    // Triangle with no dwell at the ends: turn around on the step that hits the limit.
    if (breathe_tick) begin
      if (!ramp_dn_q) begin
        if (&ramp_q) begin
          ramp_d    = ramp_q - 1'b1;
          ramp_dn_d = 1'b1;
        end else begin
          ramp_d = ramp_q + 1'b1;
        end
      end else begin
        if (ramp_q == '0) begin
          ramp_d    = ramp_q + 1'b1;
          ramp_dn_d = 1'b0;
        end else begin
          ramp_d = ramp_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ctr_q     <= '0;
      blink_q   <= 1'b0;
      ramp_q    <= '0;
      ramp_dn_q <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      ctr_q     <= ctr_d;
      blink_q   <= blink_d;
      ramp_q    <= ramp_d;
      ramp_dn_q <= ramp_dn_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_reg_t             shadow_q, shadow_d;
    ch_reg_t             active_q, active_d;
    logic [PWM_BITS-1:0] lvl;
    logic                pwm_q, pwm_d;
    logic                wr_hit;
    logic [DATA_W-1:0]   rd_fmt;

    assign wr_hit = wr_en && (bus.ADR_I == 2'(i));

    always_comb begin
      rd_fmt                    = '0;
      rd_fmt[MODE_MSB:MODE_LSB] = shadow_q.mode;
      rd_fmt[PWM_BITS-1:0]      = shadow_q.duty;
    end
    assign rd_vec[i] = rd_fmt;

    always_comb begin
      shadow_d = shadow_q;
      if (wr_hit) begin
        shadow_d.mode = bus.DAT_I[MODE_MSB:MODE_LSB];
        shadow_d.duty = bus.DAT_I[PWM_BITS-1:0];
      end
      // Copy on wrap only, so a period is never cut short; a write in the
      // wrap cycle itself misses this copy (shadow_q is still the old value).
      active_d = ctr_wrap ? shadow_q : active_q;
      case (active_q.mode)
        MODE_OFF:    lvl = '0;
        MODE_STEADY: lvl = active_q.duty;
        MODE_BLINK:  lvl = blink_q ? active_q.duty : '0;
        default:     lvl = (ramp_q < active_q.duty) ? ramp_q : active_q.duty;
      endcase
      pwm_d = (ctr_q < lvl);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
        shadow_q <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        pwm_q    <= pwm_d;
      end
    end

    assign pwm_o[i] = pwm_q;
  end

endmodule

// File: tb/tb_hd44780_led_pwm.sv
// Bench for the LED PWM dimmer: directed steps plus random register traffic against a cycle-count model.
// Latency: model predicts pwm_o/ACK_O/DAT_O one clock after each edge.
// Backpressure: bench holds STB_I until ACK_O, as a well-behaved master.
module tb_hd44780_led_pwm;

  localparam int NCH   = 3;
  localparam int PB    = 3;
  localparam int TDIV  = 16;
  localparam int BDIV  = 4;
  localparam int PER   = 1 << PB;
  localparam int TOP   = PER - 1;
  localparam logic [7:0] WMASK = 8'hC0 | 8'(TOP);

  logic           CLK_I = 1'b0;
  logic           RST_I = 1'b0;
  logic [NCH-1:0] pwm_o;

  hd44780_led_pwm_if bus ();

  always #5 CLK_I = ~CLK_I;

  hd44780_led_pwm #(
    .NUM_CH      (NCH),
    .PWM_BITS    (PB),
    .TICK_DIV    (TDIV),
    .BREATHE_DIV (BDIV)
  ) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .bus   (bus),
    .pwm_o (pwm_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]     m_shadow [NCH];
  logic [7:0]     m_active [NCH];
  logic           m_ack;
  logic [7:0]     m_dat;
  logic [NCH-1:0] m_pwm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Triangle wave value after k breathe steps: 0,1..TOP,TOP-1..1,0,1..
  function automatic int tri_f(input int k);
    int p;
    p = k % (2 * TOP);
    return (p <= TOP) ? p : 2 * TOP - p;
  endfunction

  // Level a channel register asks for during cycle c (c counted from reset release).
  function automatic int level_f(input logic [7:0] r, input int c);
    int duty, ramp;
    duty = int'(r[PB-1:0]);
    ramp = tri_f(c / BDIV);
    case (r[7:6])
      2'b00:   return 0;
      2'b01:   return duty;
      2'b10:   return (((c / TDIV) % 2) == 1) ? duty : 0;
      default: return (ramp < duty) ? ramp : duty;
    endcase
  endfunction

  task automatic model_reset();
    cyc   = 0;
    m_ack = 1'b0;
    m_dat = '0;
    m_pwm = '0;
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
  endtask

  // Advance one clock: predict, clock, then compare away from the edge.
  task automatic step();
    logic [NCH-1:0] nxt;
    int ctr;
    ctr = cyc % PER;
    for (int i = 0; i < NCH; i++) nxt[i] = (ctr < level_f(m_active[i], cyc));
    if (ctr == TOP) for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
    m_dat = '0;
    if (bus.STB_I && !m_ack && int'(bus.ADR_I) < NCH) m_dat = m_shadow[bus.ADR_I];
    if (m_ack && bus.STB_I && bus.WE_I && int'(bus.ADR_I) < NCH)
      m_shadow[bus.ADR_I] = bus.DAT_I & WMASK;
    m_ack = bus.STB_I && !m_ack;
    m_pwm = nxt;
    @(posedge CLK_I);
    #1;
    cyc++;
    chk("pwm", 32'(pwm_o), 32'(m_pwm));
    chk("ack", 32'(bus.ACK_O), 32'(m_ack));
    if (m_ack) chk("dat", 32'(bus.DAT_O), 32'(m_dat));
  endtask

  task automatic apply_reset(input int n);
    RST_I     = 1'b1;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ADR_I = '0;
    bus.DAT_I = '0;
    repeat (n) begin
      @(posedge CLK_I);
      #1;
      chk("rst_pwm", 32'(pwm_o), 32'd0);
    end
    RST_I = 1'b0;
    model_reset();
  endtask

  task automatic access(input logic we, input logic [1:0] adr, input logic [7:0] d,
                        output logic [7:0] rd);
    int n;
    bus.STB_I = 1'b1;
    bus.WE_I  = we;
    bus.ADR_I = adr;
    bus.DAT_I = d;
    step();
    n = 0;
    while (!bus.ACK_O && n < 4) begin
      step();
      n++;
    end
    chk("ack_seen", 32'(bus.ACK_O), 32'd1);
    rd = bus.DAT_O;
    step();
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
  endtask

  task automatic align(input int ph);
    for (int k = 0; k < PER && (cyc % PER) != ph; k++) step();
  endtask

  task automatic count_hi(input int ch, input int ncyc, output int n);
    n = 0;
    repeat (ncyc) begin
      n += int'(pwm_o[ch]);
      step();
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [3:0] ack_pat;
    int         n;
    bit         found;

    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ADR_I = '0;
    bus.DAT_I = '0;
    #1;
    apply_reset(3);

    // 1. idle after reset, then read back zeros
    chk("rel_pwm", 32'(pwm_o), 32'd0);
    chk("rel_ack", 32'(bus.ACK_O), 32'd0);
    repeat (100) step();
    for (int i = 0; i < NCH; i++) begin
      access(1'b0, 2'(i), 8'h00, rd);
      chk("rst_read", 32'(rd), 32'd0);
    end

    // 2. steady duty 3 on ch0
    access(1'b1, 2'd0, 8'h43, rd);
    align(1);
    count_hi(0, PER, n);
    count_hi(0, PER, n);
    chk("t2_hi", 32'(n), 32'd3);
    access(1'b0, 2'd0, 8'h00, rd);
    chk("t2_read", 32'(rd), 32'h43);

    // 3. ch1 duty 2, rewrite to 6 in the middle of a period
    access(1'b1, 2'd1, 8'h42, rd);
    align(1);
    count_hi(1, PER, n);
    chk("t3_old", 32'(n), 32'd2);
    align(2);
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    bus.ADR_I = 2'd1;
    bus.DAT_I = 8'h46;
    step();
    chk("t3_ack", 32'(bus.ACK_O), 32'd1);
    step();
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    count_hi(1, 5, n);
    chk("t3_rem", 32'(n), 32'd0);
    count_hi(1, PER, n);
    chk("t3_new", 32'(n), 32'd6);

    // 4. ch2 blink duty 7: 7/8 during one 16-clock phase, dark in the other
    access(1'b1, 2'd2, 8'h87, rd);
    align(1);
    count_hi(2, PER, n);
    count_hi(2, 2 * TDIV, n);
    chk("t4_blink", 32'(n), 32'd14);

    // 5. ch0 breathe duty 7: one full ramp cycle is 56 clocks
    access(1'b1, 2'd0, 8'hC7, rd);
    align(1);
    count_hi(0, PER, n);
    count_hi(0, 2 * TOP * BDIV, n);
    chk("t5_breathe", 32'(n), 32'd25);

    // random register traffic
    for (int k = 0; k < 40; k++) begin
      logic       we;
      logic [1:0] adr;
      logic [7:0] d, expv;
      we   = 1'($urandom % 2);
      adr  = 2'($urandom % 4);
      d    = 8'($urandom);
      expv = (int'(adr) < NCH) ? m_shadow[adr] : 8'h00;
      access(we, adr, d, rd);
      if (!we) chk("rnd_read", 32'(rd), 32'(expv));
      repeat ($urandom_range(0, 10)) step();
    end

    // 6. held strobe to an unmapped address
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    bus.ADR_I = 2'd3;
    bus.DAT_I = 8'hFF;
    #1;
    ack_pat[0] = bus.ACK_O;
    for (int k = 1; k < 4; k++) begin
      step();
      ack_pat[k] = bus.ACK_O;
      if (bus.ACK_O) chk("t6_dat", 32'(bus.DAT_O), 32'd0);
    end
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    chk("t6_ackpat", 32'(ack_pat), 32'b1010);
    step();
    for (int i = 0; i < NCH; i++) begin
      logic [7:0] expv;
      expv = m_shadow[i];
      access(1'b0, 2'(i), 8'h00, rd);
      chk("t6_keep", 32'(rd), 32'(expv));
    end

    // reset while blinking and mid-access
    access(1'b1, 2'd2, 8'h87, rd);
    bus.STB_I = 1'b1;
    bus.ADR_I = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      step();
      found = pwm_o[2] && bus.ACK_O;
    end
    chk("t6_find", 32'(found), 32'd1);
    RST_I = 1'b1;
    #1;
    chk("t6_rst_pwm", 32'(pwm_o), 32'd0);
    chk("t6_rst_ack", 32'(bus.ACK_O), 32'd0);
    chk("t6_rst_dat", 32'(bus.DAT_O), 32'd0);
    apply_reset(3);
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
